// File: rtl/opll_pkg.sv
// rtl/opll_pkg.sv - shared types and defaults for the OPLL write pacer
package opll_pkg;

    // One queued host write: target chip, register select (A0) and data byte.
    typedef struct packed {
        logic [1:0] sel;
        logic       a0;
        logic [7:0] data;
    } opll_wr_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2
    } pacer_state_t;

    localparam int DEF_WR_HOLD   = 2;
    localparam int DEF_ADDR_WAIT = 12;
    localparam int DEF_DATA_WAIT = 84;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opll_write_pacer_if.sv
// rtl/opll_write_pacer_if.sv - host-side and OPLL-side signals of the write pacer
// master: I/O port decoder side (drives host_*, observes status and OPLL bus)
// slave : the pacer itself
interface opll_write_pacer_if;
    logic       host_wr;
    logic       host_a0;
    logic [1:0] host_sel;
    logic [7:0] host_din;
    logic       host_full;
    logic       host_idle;
    logic       overflow;
    logic [7:0] opll_din;
    logic       opll_addr;
    logic [2:0] opll_wr;
    logic [2:0] opll_cs;

    modport master (
        output host_wr, host_a0, host_sel, host_din,
        input  host_full, host_idle, overflow,
        input  opll_din, opll_addr, opll_wr, opll_cs
    );

    modport slave (
        input  host_wr, host_a0, host_sel, host_din,
        output host_full, host_idle, overflow,
        output opll_din, opll_addr, opll_wr, opll_cs
    );
endinterface

// File: rtl/opll_wr_fifo.sv
// rtl/opll_wr_fifo.sv - synchronous FIFO of pending OPLL register writes
// Ports: clk, rst_n (sync, active low), push/push_data, pop/head (head is the
// entry that pop removes), full, empty, count (registered occupancy).
module opll_wr_fifo
    import opll_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  opll_wr_entry_t           push_data,
    input  logic                     pop,
    output opll_wr_entry_t           head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    opll_wr_entry_t  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/opll_write_pacer.sv
// rtl/opll_write_pacer.sv - queues host OPLL writes and replays them with legal strobe/recovery timing
// Ports: clk, rst_n (sync, active low), cen (OPLL clock enable; all timing counts cen ticks),
// bus (slave): host_wr/a0/sel/din in, host_full/host_idle/overflow status out,
// opll_din/opll_addr/opll_wr/opll_cs to the three OPLL instances (wr one-hot, cs == wr).
module opll_write_pacer
    import opll_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WR_HOLD    = DEF_WR_HOLD,
    parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int DATA_WAIT  = DEF_DATA_WAIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    opll_write_pacer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(max3(WR_HOLD, ADDR_WAIT, DATA_WAIT) + 1);

    pacer_state_t    state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            wait_data, wait_data_n;
    logic [7:0]      din_q, din_n;
    logic            addr_q, addr_n;
    logic [2:0]      wr_q, wr_n;
    logic            full_q;
    logic            idle_q;
    logic            ovf_q;

    logic            push_ok;
    logic            drop;
    logic            pop;
    opll_wr_entry_t  push_entry;
    opll_wr_entry_t  head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;
    logic [AW:0]     count_n;
    logic [CW-1:0]   wait_last;

    assign push_entry = '{sel: bus.host_sel, a0: bus.host_a0, data: bus.host_din};
    assign push_ok    = bus.host_wr && !fifo_full && (bus.host_sel != 2'd3);
    assign drop       = bus.host_wr && (fifo_full || (bus.host_sel == 2'd3));
    assign wait_last  = wait_data ? CW'(DATA_WAIT - 1) : CW'(ADDR_WAIT - 1);

    opll_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next occupancy, so host_full/host_idle can be registered without lagging a cycle.
    always_comb begin
        count_n = fifo_count;
        case ({push_ok, pop})
            2'b10:   count_n = fifo_count + 1'b1;
            2'b01:   count_n = fifo_count - 1'b1;
            default: count_n = fifo_count;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wait_data_n = wait_data;
        din_n       = din_q;
        addr_n      = addr_q;
        wr_n        = wr_q;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    din_n       = head.data;
                    addr_n      = head.a0;
                    wr_n        = 3'b001 << head.sel;
                    wait_data_n = head.a0;
                    state_n     = STROBE;
                end
            end
            STROBE: begin
                if (cen) begin
                    if (cnt == CW'(WR_HOLD - 1)) begin
                        wr_n    = '0;
                        cnt_n   = '0;
                        state_n = WAIT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            WAIT: begin
                // Recovery is shared by all chips: the next entry waits even if it targets another OPLL.
                if (cen) begin
                    if (cnt == wait_last) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                wr_n    = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wait_data <= 1'b0;
            din_q     <= '0;
            addr_q    <= 1'b0;
            wr_q      <= '0;
            full_q    <= 1'b0;
            idle_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wait_data <= wait_data_n;
            din_q     <= din_n;
            addr_q    <= addr_n;
            wr_q      <= wr_n;
            full_q    <= (count_n == (AW+1)'(FIFO_DEPTH));
            idle_q    <= (state_n == IDLE) && (count_n == '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.host_full = full_q;
    assign bus.host_idle = idle_q;
    assign bus.overflow  = ovf_q;
    assign bus.opll_din  = din_q;
    assign bus.opll_addr = addr_q;
    assign bus.opll_wr   = wr_q;
    assign bus.opll_cs   = wr_q;
endmodule

// File: tb/tb_opll_write_pacer.sv
// tb/tb_opll_write_pacer.sv - self-checking bench for opll_write_pacer
module tb_opll_write_pacer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b0;

    always #5 clk = ~clk;

    opll_write_pacer_if bus();

    opll_write_pacer #(
        .FIFO_DEPTH (8),
        .WR_HOLD    (2),
        .ADDR_WAIT  (12),
        .DATA_WAIT  (84)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int gcnt = 0;
    int ticks = 0;
    bit cen_hold = 1'b0;

    typedef struct {
        logic [1:0] sel;
        logic       a0;
        logic [7:0] din;
        logic [2:0] exp_wr;
        logic       exp_addr;
        int         exp_wait;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // One clock: counts a cen tick if cen was high at the edge, samples 1 time unit later.
    // cen pulses every third cycle, so two consecutive edges never both carry a tick.
    task automatic cyc();
        bit t;
        t = cen;
        @(posedge clk);
        #1;
        if (t) ticks++;
        gcnt++;
        cen = !cen_hold && (gcnt % 3 == 0);
    endtask

    task automatic wait_wr(input bit level, input int budget, input string name);
        int n;
        n = 0;
        while (((bus.opll_wr != 3'b000) != level) && n < budget) begin
            cyc();
            n++;
        end
        if ((bus.opll_wr != 3'b000) != level) begin
            total++;
            bad++;
            $display("FAIL %s: no opll_wr edge within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.host_idle !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        if (bus.host_idle !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: host_idle not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic a, input logic [7:0] d);
        bus.host_wr  = 1'b1;
        bus.host_sel = s;
        bus.host_a0  = a;
        bus.host_din = d;
        cyc();
        bus.host_wr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.host_wr = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        bit seen;
        bus.host_wr  = 1'b0;
        bus.host_a0  = 1'b0;
        bus.host_sel = 2'd0;
        bus.host_din = 8'h00;

        vecs[0] = '{sel: 2'd0, a0: 1'b0, din: 8'h10, exp_wr: 3'b001, exp_addr: 1'b0, exp_wait: 12};
        vecs[1] = '{sel: 2'd1, a0: 1'b1, din: 8'hA5, exp_wr: 3'b010, exp_addr: 1'b1, exp_wait: 84};
        vecs[2] = '{sel: 2'd2, a0: 1'b0, din: 8'hFF, exp_wr: 3'b100, exp_addr: 1'b0, exp_wait: 12};
        vecs[3] = '{sel: 2'd0, a0: 1'b1, din: 8'h00, exp_wr: 3'b001, exp_addr: 1'b1, exp_wait: 84};
        vecs[4] = '{sel: 2'd2, a0: 1'b1, din: 8'h3C, exp_wr: 3'b100, exp_addr: 1'b1, exp_wait: 84};

        // Reset state
        do_reset();
        chk("rst host_full", bus.host_full, 1'b0);
        chk("rst host_idle", bus.host_idle, 1'b1);
        chk("rst overflow", bus.overflow, 1'b0);
        chk("rst opll_din", bus.opll_din, 8'h00);
        chk("rst opll_addr", bus.opll_addr, 1'b0);
        chk("rst opll_wr", bus.opll_wr, 3'b000);
        chk("rst opll_cs", bus.opll_cs, 3'b000);

        // Single writes from idle: latency, strobe contents, strobe width, recovery length
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].sel, vecs[i].a0, vecs[i].din);
            chk($sformatf("v%0d wr at N+1", i), bus.opll_wr, 3'b000);
            chk($sformatf("v%0d idle at N+1", i), bus.host_idle, 1'b0);
            cyc();
            chk($sformatf("v%0d wr at N+2", i), bus.opll_wr, vecs[i].exp_wr);
            chk($sformatf("v%0d cs", i), bus.opll_cs, vecs[i].exp_wr);
            chk($sformatf("v%0d din", i), bus.opll_din, vecs[i].din);
            chk($sformatf("v%0d addr", i), bus.opll_addr, vecs[i].exp_addr);
            ticks = 0;
            wait_wr(1'b0, 100, $sformatf("v%0d strobe end", i));
            chk($sformatf("v%0d strobe ticks", i), ticks, 2);
            ticks = 0;
            wait_idle(1000, $sformatf("v%0d idle", i));
            chk($sformatf("v%0d wait ticks", i), ticks, vecs[i].exp_wait);
            chk($sformatf("v%0d din held", i), bus.opll_din, vecs[i].din);
        end

        // Back-to-back address/data pair to the internal chip
        push(2'd2, 1'b0, 8'h30);
        push(2'd2, 1'b1, 8'h5F);
        wait_wr(1'b1, 20, "pair first rise");
        chk("pair first wr", bus.opll_wr, 3'b100);
        chk("pair first din", bus.opll_din, 8'h30);
        chk("pair first addr", bus.opll_addr, 1'b0);
        wait_wr(1'b0, 100, "pair first fall");
        ticks = 0;
        wait_wr(1'b1, 500, "pair second rise");
        chk("pair gap ticks", ticks, 12);
        chk("pair second wr", bus.opll_wr, 3'b100);
        chk("pair second din", bus.opll_din, 8'h5F);
        chk("pair second addr", bus.opll_addr, 1'b1);
        wait_wr(1'b0, 100, "pair second fall");
        ticks = 0;
        wait_idle(1000, "pair idle");
        chk("pair data wait ticks", ticks, 84);

        // cen frozen for 200 clocks in the middle of a data recovery
        push(2'd1, 1'b1, 8'h77);
        wait_wr(1'b1, 20, "freeze rise");
        wait_wr(1'b0, 100, "freeze fall");
        ticks = 0;
        for (int n = 0; n < 100 && ticks < 10; n++) cyc();
        chk("freeze pre ticks", ticks, 10);
        cen_hold = 1'b1;
        cen = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cyc();
            if (bus.host_idle !== 1'b0 || bus.opll_wr !== 3'b000) seen = 1'b1;
        end
        chk("freeze state held", seen, 1'b0);
        cen_hold = 1'b0;
        ticks = 0;
        wait_idle(1000, "freeze resume idle");
        chk("freeze remaining ticks", ticks, 74);

        // sel=3 is dropped and flagged
        do_reset();
        push(2'd3, 1'b0, 8'h99);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (bus.opll_wr !== 3'b000) seen = 1'b1;
        end
        chk("sel3 no strobe", seen, 1'b0);
        chk("sel3 overflow", bus.overflow, 1'b1);
        chk("sel3 idle", bus.host_idle, 1'b1);

        // Burst into a full FIFO: 9 accepted (one already popped), 10th dropped
        do_reset();
        chk("burst overflow clear", bus.overflow, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.host_wr  = 1'b1;
            bus.host_sel = 2'd1;
            bus.host_a0  = 1'b0;
            bus.host_din = 8'h80 + 8'(i);
            cyc();
            if (i == 7) chk("burst full after 8", bus.host_full, 1'b0);
            if (i == 8) begin
                chk("burst full after 9", bus.host_full, 1'b1);
                chk("burst overflow after 9", bus.overflow, 1'b0);
            end
            if (i == 9) chk("burst overflow after 10", bus.overflow, 1'b1);
        end
        bus.host_wr = 1'b0;
        for (int k = 1; k < 9; k++) begin
            wait_wr(1'b1, 500, $sformatf("burst rise %0d", k));
            if (k > 1) chk($sformatf("burst gap %0d", k), ticks, 12);
            chk($sformatf("burst din %0d", k), bus.opll_din, 8'h80 + 8'(k));
            chk($sformatf("burst wr %0d", k), bus.opll_wr, 3'b010);
            ticks = 0;
            wait_wr(1'b0, 100, $sformatf("burst fall %0d", k));
            chk($sformatf("burst strobe %0d", k), ticks, 2);
            ticks = 0;
        end
        wait_idle(500, "burst idle");
        chk("burst last wait", ticks, 12);
        chk("burst full cleared", bus.host_full, 1'b0);

        // Reset during the third of five strobes
        do_reset();
        for (int i = 0; i < 5; i++) push(2'd0, 1'b0, 8'h40 + 8'(i));
        for (int s = 0; s < 3; s++) begin
            wait_wr(1'b1, 500, $sformatf("rst rise %0d", s));
            if (s < 2) wait_wr(1'b0, 100, $sformatf("rst fall %0d", s));
        end
        chk("rst3 din before", bus.opll_din, 8'h42);
        rst_n = 1'b0;
        cyc();
        chk("rst3 wr cleared", bus.opll_wr, 3'b000);
        chk("rst3 cs cleared", bus.opll_cs, 3'b000);
        chk("rst3 din cleared", bus.opll_din, 8'h00);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            cyc();
            if (bus.opll_wr !== 3'b000) seen = 1'b1;
        end
        chk("rst3 no more strobes", seen, 1'b0);
        chk("rst3 idle", bus.host_idle, 1'b1);
        chk("rst3 full", bus.host_full, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
